// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared state encoding and default widths for the pulse train generator
package pulse_gen_pkg;

    localparam int CW_DEFAULT = 8;
    localparam int NW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter with zero flag for phase timing
module phase_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    // Load wins over enable; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - generates num_pulses pulses of programmable high/low length after start
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] low_len,
    input  logic [NW-1:0] num_pulses,
    output logic          sig,
    output logic          pe,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [CW-1:0] hl_m1;
    logic [CW-1:0] ll_m1;
    logic [NW-1:0] pulses_left;

    logic          cnt_load;
    logic          cnt_en;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;

    // The counter holds cycles remaining after the current one, so a length of
    // 0 or 1 both load 0 and give a single-cycle phase.
    function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - CW'(1);
    endfunction

    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = hl_m1;
        case (state)
            IDLE: begin
                if (start && (num_pulses != '0)) begin
                    cnt_load = 1'b1;
                    cnt_val  = len_m1(high_len);
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = ll_m1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LOW: begin
                if (cnt_zero && (pulses_left != NW'(1))) begin
                    cnt_load = 1'b1;
                    cnt_val  = hl_m1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    phase_counter #(
        .CW(CW)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (cnt_en),
        .load_val(cnt_val),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sig         <= 1'b0;
            pe          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hl_m1       <= '0;
            ll_m1       <= '0;
            pulses_left <= '0;
        end else begin
            pe   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hl_m1       <= len_m1(high_len);
                        ll_m1       <= len_m1(low_len);
                        pulses_left <= num_pulses;
                        if (num_pulses != '0) begin
                            state <= HIGH;
                            sig   <= 1'b1;
                            pe    <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state <= LOW;
                        sig   <= 1'b0;
                    end
                end
                LOW: begin
                    if (cnt_zero) begin
                        if (pulses_left == NW'(1)) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            pulses_left <= '0;
                        end else begin
                            pulses_left <= pulses_left - NW'(1);
                            state       <= HIGH;
                            sig         <= 1'b1;
                            pe          <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sig   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
